axil_cmd_master: RTL and testbench
==================================

AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width; strobe width is C_M_AXI_DATA_WIDTH/8.
REQ-003 SHALL have port m_axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port m_axi_aresetn  in  1  asynchronous active-low reset.
REQ-005 SHALL have command ports: cmd_valid in 1; cmd_ready out 1; cmd_we in 1 (1=write, 0=read); cmd_addr in ADDR; cmd_wdata in DATA; cmd_wstrb in DATA/8.
REQ-006 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_we out 1 (echo of cmd_we); rsp_rdata out DATA (0 for writes); rsp_resp out 2 (BRESP/RRESP).
REQ-007 SHALL have AXI4-Lite master ports: m_axi_awaddr/awprot/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arprot/arvalid/arready, m_axi_rdata/rresp/rvalid/rready, widths per AXI4-Lite.
REQ-008 SHALL have port err_count  out 16  saturating count of non-OKAY responses.

Function
REQ-009 SHALL implement states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
REQ-010 cmd_ready SHALL be 1 only in IDLE; command accepted on edge with cmd_valid&cmd_ready; addr/wdata/wstrb/we registered at that edge.
REQ-011 Accepted write SHALL go to WR_REQ with m_axi_awvalid=1 and m_axi_wvalid=1 from next cycle (registered, no combinational path from cmd_* to AXI outputs).
REQ-012 In WR_REQ awvalid and wvalid SHALL each drop the cycle after its own handshake, independently; AW and W may complete in same or different cycles in either order.
REQ-013 Valid signals SHALL never drop before their handshake; address, data and strobe SHALL stay stable while valid is high.
REQ-014 When both AW and W have completed, FSM SHALL enter WR_RESP with m_axi_bready=1; on bvalid&bready capture bresp, drop bready, go to RSP.
REQ-015 Accepted read SHALL go to RD_REQ with m_axi_arvalid=1; on arvalid&arready drop arvalid, go to RD_RESP with m_axi_rready=1; on rvalid&rready capture rdata/rresp, drop rready, go to RSP.
REQ-016 In RSP rsp_valid SHALL be 1 with stable rsp_*; on rsp_valid&rsp_ready return to IDLE; cmd_ready may not rise in the same cycle (one-transaction-in-flight).
REQ-017 Minimum latency, slave always ready: command accept edge N, AW/W handshake edge N+1, B handshake earliest edge N+2, rsp_valid high from N+3.
REQ-018 m_axi_awprot and m_axi_arprot SHALL be constant 3'b000.
REQ-019 bready and rready SHALL be 0 outside WR_RESP/RD_RESP; bvalid/rvalid arriving elsewhere SHALL be ignored.
REQ-020 err_count SHALL increment by 1 on each captured response with resp != 2'b00, saturating at 16'hFFFF.
REQ-021 Write response SHALL set rsp_rdata=0; rsp_we SHALL equal captured cmd_we.

Reset
REQ-022 On m_axi_aresetn=0 FSM SHALL enter IDLE immediately; all valid/ready outputs 0 except cmd_ready, which is 0 during reset and 1 the first cycle after release.
REQ-023 Reset SHALL clear err_count, rsp_rdata, rsp_resp, rsp_we and all AXI address/data/strobe registers to 0.
REQ-024 Reset mid-transaction SHALL abandon it silently; no response is produced for it.

Structure
REQ-025 State encoding and AXI response constants (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) SHALL live in shared package axil_pkg.
REQ-026 Block SHALL be one flat module; no sub-module required.

Verification
REQ-027 Write addr 0x0, data 0x0000_000A, strb 0xF, slave always ready -> one AW and one W beat, rsp_valid at N+3, rsp_resp=00, err_count=0.
REQ-028 Write with slave wready 3 cycles before awready -> wvalid drops after W beat, awvalid held until AW beat, single B accepted, rsp_resp=00.
REQ-029 Read addr 0x4, slave returns rdata 0xDEAD_BEEF, rresp=00 after 2 wait cycles -> rsp_rdata=0xDEAD_BEEF, rsp_we=0.
REQ-030 Write answered bresp=10 then read answered rresp=11 -> rsp_resp 10 then 11, err_count=2.
REQ-031 rsp_ready held low 5 cycles -> rsp_valid and rsp_* stable, cmd_ready=0, no new AXI traffic; back-to-back 16 writes of data 0..15 to addr 0 all complete in order.
REQ-032 Assert m_axi_aresetn low while awvalid=1 -> all valids drop asynchronously, no rsp_valid, cmd_ready=1 the cycle after release.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite command master.
// Contents:
//   state_t    - command master FSM states
//   RESP_*     - AXI response codes carried on BRESP/RRESP
//   PROT_NONE  - fixed AxPROT value (unprivileged, secure, data)
//   sat_inc16  - 16-bit increment that sticks at all-ones
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_NONE = 3'b000;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between the command master and a slave.
// Parameters: ADDR_WIDTH, DATA_WIDTH (strobe is DATA_WIDTH/8).
// Modports:
//   master - drives AW/W/AR payload+valid, B/R ready
//   slave  - drives AW/W/AR ready, B/R payload+valid
interface axil_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0]   m_axi_awaddr;
  logic [2:0]              m_axi_awprot;
  logic                    m_axi_awvalid;
  logic                    m_axi_awready;
  logic [DATA_WIDTH-1:0]   m_axi_wdata;
  logic [DATA_WIDTH/8-1:0] m_axi_wstrb;
  logic                    m_axi_wvalid;
  logic                    m_axi_wready;
  logic [1:0]              m_axi_bresp;
  logic                    m_axi_bvalid;
  logic                    m_axi_bready;
  logic [ADDR_WIDTH-1:0]   m_axi_araddr;
  logic [2:0]              m_axi_arprot;
  logic                    m_axi_arvalid;
  logic                    m_axi_arready;
  logic [DATA_WIDTH-1:0]   m_axi_rdata;
  logic [1:0]              m_axi_rresp;
  logic                    m_axi_rvalid;
  logic                    m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready,
    output m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    output m_axi_rready
  );

  modport slave (
    input  m_axi_awaddr, m_axi_awprot, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready,
    input  m_axi_araddr, m_axi_arprot, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid,
    input  m_axi_rready
  );

endinterface

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a simple command/response
// handshake. One command is accepted in IDLE, turned into an AXI write
// (AW+W, then B) or read (AR, then R), and the result is held on rsp_*
// until taken. All AXI outputs are registered.
// Ports:
//   m_axi_aclk, m_axi_aresetn - clock, async active-low reset
//   cmd_*      - command in (valid/ready, we, addr, wdata, wstrb)
//   rsp_*      - response out (valid/ready, we echo, rdata, resp)
//   err_count  - saturating count of non-OKAY responses
//   m_axi      - AXI4-Lite master bus (axil_cmd_master_if.master)
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_aresetn,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_we,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_we,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic [15:0]                     err_count,
  axil_cmd_master_if.master               m_axi
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  state_t                          state_q, state_d;
  logic                            cmd_ready_q, cmd_ready_d;
  logic                            awvalid_q, awvalid_d;
  logic                            wvalid_q, wvalid_d;
  logic                            bready_q, bready_d;
  logic                            arvalid_q, arvalid_d;
  logic                            rready_q, rready_d;
  logic                            rsp_valid_q, rsp_valid_d;
  logic                            we_q, we_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]               wstrb_q, wstrb_d;
  logic [C_M_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]                      resp_q, resp_d;
  logic [15:0]                     err_q, err_d;
  logic                            aw_done, w_done;

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= RESP_OKAY;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    err_d       = err_q;
    // A channel counts as done once its valid is gone or is handshaking now.
    aw_done     = !awvalid_q || m_axi.m_axi_awready;
    w_done      = !wvalid_q || m_axi.m_axi_wready;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          we_d    = cmd_we;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          if (cmd_we) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (awvalid_q && m_axi.m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.m_axi_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axi.m_axi_bvalid && bready_q) begin
          bready_d    = 1'b0;
          rdata_d     = '0;
          resp_d      = m_axi.m_axi_bresp;
          if (m_axi.m_axi_bresp != RESP_OKAY) err_d = sat_inc16(err_q);
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RD_REQ: begin
        if (arvalid_q && m_axi.m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_RESP;
        end
      end
      RD_RESP: begin
        if (m_axi.m_axi_rvalid && rready_q) begin
          rready_d    = 1'b0;
          rdata_d     = m_axi.m_axi_rdata;
          resp_d      = m_axi.m_axi_rresp;
          if (m_axi.m_axi_rresp != RESP_OKAY) err_d = sat_inc16(err_q);
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered so it stays low through reset and only rises once the
    // FSM is actually sitting in IDLE.
    cmd_ready_d = (state_d == IDLE);
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_we    = we_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign err_count = err_q;

  assign m_axi.m_axi_awaddr  = addr_q;
  assign m_axi.m_axi_awprot  = PROT_NONE;
  assign m_axi.m_axi_awvalid = awvalid_q;
  assign m_axi.m_axi_wdata   = wdata_q;
  assign m_axi.m_axi_wstrb   = wstrb_q;
  assign m_axi.m_axi_wvalid  = wvalid_q;
  assign m_axi.m_axi_bready  = bready_q;
  assign m_axi.m_axi_araddr  = addr_q;
  assign m_axi.m_axi_arprot  = PROT_NONE;
  assign m_axi.m_axi_arvalid = arvalid_q;
  assign m_axi.m_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Testbench for axil_cmd_master: a behavioural AXI4-Lite slave with
// programmable per-channel wait states, a command driver, and a
// transaction-level expectation (response code/read data derived from the
// address, saturating error count) checked per command.
module tb_axil_cmd_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] err_count;

  axil_cmd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi ();

  axil_cmd_master #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_we        (cmd_we),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_wstrb     (cmd_wstrb),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_we        (rsp_we),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .err_count     (err_count),
    .m_axi         (axi)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] model_err = '0;

  // slave knobs set by the main sequence
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  bit spurious_b = 0;

  // slave bookkeeping
  int aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0, r_beats = 0;
  logic [31:0] slv_awaddr = '0, slv_wdata = '0, slv_araddr = '0;
  logic [3:0]  slv_wstrb = '0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Response code is decoded from address bits: region [7:6]==3 answers
  // with the code held in [5:4], everything else answers OKAY.
  function automatic logic [1:0] resp_for(input logic [31:0] a);
    return (a[7:6] == 2'b11) ? a[5:4] : 2'b00;
  endfunction

  // Read data is a scramble of the address; address 0x4 yields 0xDEADBEEF.
  function automatic logic [31:0] rdata_for(input logic [31:0] a);
    return 32'hDEAD_BEEF ^ ((a - 32'd4) * 32'h9E37_79B1);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural slave: decides ready/valid at each falling edge, so a
  // handshake at the following rising edge is known in advance.
  initial begin
    bit aw_hs_p = 0, w_hs_p = 0, ar_hs_p = 0, b_hs_p = 0, r_hs_p = 0;
    bit aw_hold = 0, w_hold = 0, ar_hold = 0;
    bit wr_addr_got = 0, wr_data_got = 0, rd_addr_got = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic [31:0] prev_awaddr = '0, prev_wdata = '0, prev_araddr = '0;
    logic [3:0]  prev_wstrb = '0;
    axi.m_axi_awready = 0; axi.m_axi_wready = 0; axi.m_axi_arready = 0;
    axi.m_axi_bvalid = 0; axi.m_axi_bresp = 0;
    axi.m_axi_rvalid = 0; axi.m_axi_rresp = 0; axi.m_axi_rdata = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi.m_axi_awready = 0; axi.m_axi_wready = 0; axi.m_axi_arready = 0;
        axi.m_axi_bvalid = 0; axi.m_axi_rvalid = 0;
        aw_hs_p = 0; w_hs_p = 0; ar_hs_p = 0; b_hs_p = 0; r_hs_p = 0;
        aw_hold = 0; w_hold = 0; ar_hold = 0;
        wr_addr_got = 0; wr_data_got = 0; rd_addr_got = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      end else begin
        if (aw_hs_p) begin
          slv_awaddr = prev_awaddr; aw_beats++; wr_addr_got = 1;
          checkOutput("awvalid_drop", axi.m_axi_awvalid, 0);
        end else if (aw_hold) begin
          checkOutput("awvalid_hold", axi.m_axi_awvalid, 1);
          checkOutput("awaddr_stable", axi.m_axi_awaddr, prev_awaddr);
        end
        if (w_hs_p) begin
          slv_wdata = prev_wdata; slv_wstrb = prev_wstrb; w_beats++; wr_data_got = 1;
          checkOutput("wvalid_drop", axi.m_axi_wvalid, 0);
        end else if (w_hold) begin
          checkOutput("wvalid_hold", axi.m_axi_wvalid, 1);
          checkOutput("wdata_stable", axi.m_axi_wdata, prev_wdata);
          checkOutput("wstrb_stable", axi.m_axi_wstrb, prev_wstrb);
        end
        if (ar_hs_p) begin
          slv_araddr = prev_araddr; ar_beats++; rd_addr_got = 1;
          checkOutput("arvalid_drop", axi.m_axi_arvalid, 0);
        end else if (ar_hold) begin
          checkOutput("arvalid_hold", axi.m_axi_arvalid, 1);
          checkOutput("araddr_stable", axi.m_axi_araddr, prev_araddr);
        end
        if (b_hs_p) begin
          checkOutput("b_expected", wr_addr_got && wr_data_got, 1);
          b_beats++; wr_addr_got = 0; wr_data_got = 0; b_cnt = 0;
          axi.m_axi_bvalid = 0;
        end
        if (r_hs_p) begin
          checkOutput("r_expected", rd_addr_got, 1);
          r_beats++; rd_addr_got = 0; r_cnt = 0;
          axi.m_axi_rvalid = 0;
        end

        if (axi.m_axi_awvalid) begin
          axi.m_axi_awready = (aw_cnt >= aw_delay); aw_cnt++;
        end else begin
          axi.m_axi_awready = 0; aw_cnt = 0;
        end
        aw_hs_p = axi.m_axi_awvalid && axi.m_axi_awready;
        aw_hold = axi.m_axi_awvalid && !axi.m_axi_awready;
        prev_awaddr = axi.m_axi_awaddr;
        if (aw_hs_p) aw_cnt = 0;

        if (axi.m_axi_wvalid) begin
          axi.m_axi_wready = (w_cnt >= w_delay); w_cnt++;
        end else begin
          axi.m_axi_wready = 0; w_cnt = 0;
        end
        w_hs_p = axi.m_axi_wvalid && axi.m_axi_wready;
        w_hold = axi.m_axi_wvalid && !axi.m_axi_wready;
        prev_wdata = axi.m_axi_wdata;
        prev_wstrb = axi.m_axi_wstrb;
        if (w_hs_p) w_cnt = 0;

        if (axi.m_axi_arvalid) begin
          axi.m_axi_arready = (ar_cnt >= ar_delay); ar_cnt++;
        end else begin
          axi.m_axi_arready = 0; ar_cnt = 0;
        end
        ar_hs_p = axi.m_axi_arvalid && axi.m_axi_arready;
        ar_hold = axi.m_axi_arvalid && !axi.m_axi_arready;
        prev_araddr = axi.m_axi_araddr;
        if (ar_hs_p) ar_cnt = 0;

        if (wr_addr_got && wr_data_got) begin
          if (!axi.m_axi_bvalid) begin
            if (b_cnt >= b_delay) begin
              axi.m_axi_bvalid = 1; axi.m_axi_bresp = resp_for(slv_awaddr);
            end else b_cnt++;
          end
        end else begin
          axi.m_axi_bvalid = spurious_b; axi.m_axi_bresp = 2'b10;
        end
        b_hs_p = axi.m_axi_bvalid && axi.m_axi_bready;

        if (rd_addr_got) begin
          if (!axi.m_axi_rvalid) begin
            if (r_cnt >= r_delay) begin
              axi.m_axi_rvalid = 1;
              axi.m_axi_rdata = rdata_for(slv_araddr);
              axi.m_axi_rresp = resp_for(slv_araddr);
            end else r_cnt++;
          end
        end else begin
          axi.m_axi_rvalid = 0; axi.m_axi_rdata = $urandom; axi.m_axi_rresp = 2'b11;
        end
        r_hs_p = axi.m_axi_rvalid && axi.m_axi_rready;
      end
    end
  end

  // Issue one command (called at a falling edge), collect and check its
  // response. hold = cycles rsp_ready stays low after rsp_valid appears.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               input int hold, input bit chk_lat);
    int base_aw, base_w, base_b, base_ar, base_r;
    int acc, n;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    base_aw = aw_beats; base_w = w_beats; base_b = b_beats;
    base_ar = ar_beats; base_r = r_beats;
    exp_resp  = resp_for(addr);
    exp_rdata = we ? 32'h0 : rdata_for(addr);
    if (exp_resp != 2'b00 && model_err != 16'hFFFF) model_err++;

    cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checkOutput("cmd_accept_timeout", 0, 1);
      cmd_valid = 0;
      return;
    end
    @(negedge clk);
    acc = cyc;
    cmd_valid = 0; cmd_we = $urandom; cmd_addr = $urandom;
    cmd_wdata = $urandom; cmd_wstrb = $urandom;
    checkOutput("req_awvalid", axi.m_axi_awvalid, we);
    checkOutput("req_wvalid", axi.m_axi_wvalid, we);
    checkOutput("req_arvalid", axi.m_axi_arvalid, !we);
    checkOutput("cmd_ready_busy", cmd_ready, 0);

    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      checkOutput("rsp_timeout", 0, 1);
      return;
    end
    // rsp_valid appears after edge N+2, i.e. it is high when edge N+3 samples it.
    if (chk_lat) checkOutput("rsp_latency", cyc - acc, 2);

    for (int h = 0; h <= hold; h++) begin
      checkOutput("rsp_valid", rsp_valid, 1);
      checkOutput("rsp_we", rsp_we, we);
      checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
      checkOutput("rsp_resp", rsp_resp, exp_resp);
      checkOutput("err_count", err_count, model_err);
      checkOutput("rsp_cmd_ready", cmd_ready, 0);
      checkOutput("rsp_bus_quiet", {axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_arvalid}, 0);
      if (h < hold) @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    checkOutput("rsp_valid_clear", rsp_valid, 0);
    checkOutput("cmd_ready_back", cmd_ready, 1);

    checkOutput("aw_beats", aw_beats - base_aw, we ? 1 : 0);
    checkOutput("w_beats", w_beats - base_w, we ? 1 : 0);
    checkOutput("b_beats", b_beats - base_b, we ? 1 : 0);
    checkOutput("ar_beats", ar_beats - base_ar, we ? 0 : 1);
    checkOutput("r_beats", r_beats - base_r, we ? 0 : 1);
    if (we) begin
      checkOutput("slave_awaddr", slv_awaddr, addr);
      checkOutput("slave_wdata", slv_wdata, data);
      checkOutput("slave_wstrb", slv_wstrb, strb);
    end else begin
      checkOutput("slave_araddr", slv_araddr, addr);
    end
  endtask

  initial begin
    int quiet;
    rst_n = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0;
    cmd_wstrb = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_cmd_ready", cmd_ready, 0);
    checkOutput("reset_valids", {axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_arvalid,
                                 axi.m_axi_bready, axi.m_axi_rready, rsp_valid}, 0);
    checkOutput("reset_err_count", err_count, 0);
    checkOutput("reset_rsp_fields", {rsp_we, rsp_rdata, rsp_resp}, 0);
    checkOutput("reset_axi_payload", {axi.m_axi_awaddr, axi.m_axi_wdata, axi.m_axi_wstrb}, 0);
    checkOutput("prot_const", {axi.m_axi_awprot, axi.m_axi_arprot}, 0);
    #1 rst_n = 1;
    @(negedge clk);
    checkOutput("cmd_ready_after_reset", cmd_ready, 1);

    $display("[TB] basic write, slave always ready");
    applyStimulus(1, 32'h0, 32'h0000_000A, 4'hF, 0, 1);

    $display("[TB] write with W accepted three cycles before AW");
    aw_delay = 3;
    applyStimulus(1, 32'h10, 32'h1234_5678, 4'h5, 0, 0);
    aw_delay = 0;

    $display("[TB] read 0x4 with two R wait cycles");
    r_delay = 2;
    applyStimulus(0, 32'h4, 32'h0, 4'h0, 0, 0);
    r_delay = 0;

    $display("[TB] error responses");
    applyStimulus(1, 32'hE0, 32'hCAFE_0001, 4'hF, 0, 0);
    applyStimulus(0, 32'hF0, 32'h0, 4'h0, 0, 0);
    checkOutput("err_count_two", err_count, 16'd2);

    $display("[TB] stray B while idle");
    spurious_b = 1;
    repeat (4) @(negedge clk);
    checkOutput("idle_bready", axi.m_axi_bready, 0);
    checkOutput("idle_no_rsp", rsp_valid, 0);
    checkOutput("idle_err_count", err_count, 16'd2);
    spurious_b = 0;
    @(negedge clk);

    $display("[TB] response back-pressure");
    applyStimulus(1, 32'h20, 32'h5555_AAAA, 4'hC, 5, 0);

    $display("[TB] sixteen back-to-back writes");
    for (int i = 0; i < 16; i++) applyStimulus(1, 32'h0, i, 4'hF, 0, 0);

    $display("[TB] reset during a write");
    aw_delay = 6; w_delay = 6;
    cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h30; cmd_wdata = 32'h0BAD_F00D; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    checkOutput("rst_mid_awvalid", axi.m_axi_awvalid, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    checkOutput("rst_async_valids", {axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_arvalid,
                                     axi.m_axi_bready, axi.m_axi_rready}, 0);
    checkOutput("rst_async_cmd_ready", cmd_ready, 0);
    checkOutput("rst_async_rsp_valid", rsp_valid, 0);
    checkOutput("rst_async_err_count", err_count, 0);
    model_err = '0;
    aw_delay = 0; w_delay = 0;
    @(negedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    checkOutput("rst_release_cmd_ready", cmd_ready, 1);
    quiet = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid || axi.m_axi_awvalid || axi.m_axi_wvalid || axi.m_axi_arvalid) quiet++;
    end
    checkOutput("rst_abandoned_silent", quiet, 0);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 40; t++) begin
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
      r_delay  = $urandom_range(0, 3);
      applyStimulus(1'($urandom_range(0, 1)), $urandom & 32'h0000_0FFC, $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 2), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
